relu_fwd_mask: RTL and testbench
================================

RELU_FWD_MASK -- requirements
Module: relu_fwd_mask

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32: float word width in IEEE-754 single format.
REQ-002 SHALL have parameter DEPTH, default 64: number of mask-FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have input clear, 1 bit: synchronous flush of the FIFO and both output stages.
REQ-006 SHALL have inputs fwd_valid (1 bit) and fwd_data (BITWIDTH bits), and output fwd_ready (1 bit): the forward activation input stream.
REQ-007 SHALL have outputs act_valid (1 bit) and act_data (BITWIDTH bits), and input act_ready (1 bit): the ReLU result stream.
REQ-008 SHALL have inputs bwd_valid (1 bit) and bwd_grad (BITWIDTH bits), and output bwd_ready (1 bit): the incoming gradient stream.
REQ-009 SHALL have outputs grad_valid (1 bit) and grad_data (BITWIDTH bits), and input grad_ready (1 bit): the gated gradient stream.
REQ-010 SHALL have outputs mask_count ($clog2(DEPTH+1) bits), mask_full (1 bit) and mask_empty (1 bit): FIFO status.

Function
REQ-011 SHALL compute the mask bit m = fwd_data[BITWIDTH-1], so negative values and -0.0 give m=1.
REQ-012 SHALL output act_data = 0 (+0.0) when m=1, and fwd_data unchanged otherwise.
REQ-013 SHALL drive fwd_ready = !mask_full && (!act_valid || act_ready).
REQ-014 SHALL, on each forward handshake (fwd_valid && fwd_ready), register act_data/act_valid at the next edge (latency 1) and push m into the FIFO in the same cycle.
REQ-015 SHALL hold act_valid high with act_data stable until act_ready is sampled high.
REQ-016 SHALL drive bwd_ready = !mask_empty && (!grad_valid || grad_ready).
REQ-017 SHALL, on each backward handshake, pop the oldest mask bit and register grad_data = (bit ? 0 : bwd_grad) with grad_valid at the next edge (latency 1).
REQ-018 SHALL hold grad_valid high with grad_data stable until grad_ready is sampled high.
REQ-019 SHALL return masks in strict FIFO order: the Nth backward handshake uses the Nth pushed mask.
REQ-020 SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-021 SHALL count mask_count 0..DEPTH, with mask_full = (count==DEPTH) and mask_empty = (count==0).
REQ-022 SHALL, on a simultaneous push and pop, leave mask_count unchanged and move both pointers.
REQ-023 SHALL keep fwd_ready low when full, even if a pop occurs in the same cycle (no same-cycle free-slot reuse).
REQ-024 SHALL keep bwd_ready low when empty, even if a push occurs in the same cycle (no bypass path).
REQ-025 SHALL, on clear, zero the pointers and count, deassert act_valid and grad_valid, and ignore same-cycle handshakes; clear has priority over push and pop.

Reset
REQ-026 SHALL, while rst is high, hold act_valid=0, grad_valid=0, act_data=0, grad_data=0, mask_count=0, mask_empty=1, mask_full=0, fwd_ready=0 and bwd_ready=0.
REQ-027 SHALL discard all in-flight data and masks when rst asserts mid-stream; the first cycle after release equals the post-reset state.

Configuration
REQ-028 SHALL, with macro RELU_NAN_PROPAGATE_EN defined, treat a NaN input (exponent all ones, mantissa nonzero) as: act_data = fwd_data unchanged, pushed mask bit = 0.
REQ-029 SHALL, without RELU_NAN_PROPAGATE_EN, decide act_data and the mask bit from the sign bit alone, NaNs included.

Structure
REQ-030 SHALL place the constants FLOAT_ZERO (32'h00000000) and FLOAT_1 (32'h3F800000), the float_t typedef, and the NaN-detect function in shared package relu_pkg.
REQ-031 SHALL implement the mask storage as sub-module relu_mask_fifo: a 1-bit-wide synchronous FIFO with push, pop, clear, count, full and empty.

Verification
REQ-032 SHALL check: fwd_data 0x40400000 (3.0) then 0xC0000000 (-2.0), act_ready=1 -> act_data 0x40400000 then 0x00000000, one cycle after each handshake; mask_count=2.
REQ-033 SHALL check: after REQ-032, bwd_grad 0x3F000000 then 0x3F000000 -> grad_data 0x3F000000 then 0x00000000; mask_count=0, mask_empty=1.
REQ-034 SHALL check: 64 pushes with no pops -> mask_full=1 and fwd_ready=0; then push and pop in the same cycle -> no push accepted, count=63; order preserved across the pointer wrap.
REQ-035 SHALL check: act_ready held 0 for 5 cycles with act_valid=1 -> act_data stable and fwd_ready=0; on release, no data lost or duplicated.
REQ-036 SHALL check: fwd_data 0x80000000 (-0.0) -> act_data 0; fwd_data 0xFFC00000 (NaN) -> act_data 0xFFC00000 with mask 0 when RELU_NAN_PROPAGATE_EN is defined, and 0 with mask 1 when it is not.
REQ-037 SHALL check: rst or clear asserted with 10 masks queued and both outputs valid -> count 0, both valids 0, and the next push/pop pair behaves as the first.

Source files
------------

// File: rtl/relu_pkg.sv
// relu_pkg: shared float constants, float_t and NaN detect for the ReLU slice.
// No ports; imported by relu_fwd_mask and its bench.
package relu_pkg;

  typedef logic [31:0] float_t;

  localparam float_t FLOAT_ZERO = 32'h00000000;
  localparam float_t FLOAT_1    = 32'h3F800000;

  // Exponent all ones with a nonzero mantissa.
  function automatic logic relu_is_nan(float_t f);
    return (f[30:23] == 8'hFF) && (f[22:0] != '0);
  endfunction

endpackage

// File: rtl/relu_fwd_mask_if.sv
// relu_fwd_mask_if: forward/act/backward/grad streams plus mask FIFO status.
// master = stream source/sink side, slave = the relu_fwd_mask block.
interface relu_fwd_mask_if #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 64
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                fwd_valid;
  logic [BITWIDTH-1:0] fwd_data;
  logic                fwd_ready;

  logic                act_valid;
  logic [BITWIDTH-1:0] act_data;
  logic                act_ready;

  logic                bwd_valid;
  logic [BITWIDTH-1:0] bwd_grad;
  logic                bwd_ready;

  logic                grad_valid;
  logic [BITWIDTH-1:0] grad_data;
  logic                grad_ready;

  logic [CW-1:0]       mask_count;
  logic                mask_full;
  logic                mask_empty;

  modport master (
    output fwd_valid, fwd_data, act_ready,
    output bwd_valid, bwd_grad, grad_ready,
    input  fwd_ready, act_valid, act_data,
    input  bwd_ready, grad_valid, grad_data,
    input  mask_count, mask_full, mask_empty
  );

  modport slave (
    input  fwd_valid, fwd_data, act_ready,
    input  bwd_valid, bwd_grad, grad_ready,
    output fwd_ready, act_valid, act_data,
    output bwd_ready, grad_valid, grad_data,
    output mask_count, mask_full, mask_empty
  );

endinterface

// File: rtl/relu_mask_fifo.sv
// relu_mask_fifo: 1-bit-wide synchronous FIFO of ReLU mask bits.
// Ports: clk, rst, clear, push/din, pop/dout, count, full, empty.
module relu_mask_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/relu_fwd_mask.sv
// relu_fwd_mask: ReLU forward with mask FIFO gating the backward gradient.
// Ports: clk, rst (async high), clear, bus (relu_fwd_mask_if.slave); macro RELU_NAN_PROPAGATE_EN.
module relu_fwd_mask
  import relu_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 64
) (
  input logic           clk,
  input logic           rst,
  input logic           clear,
  relu_fwd_mask_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                m;
  logic [BITWIDTH-1:0] relu_out;
  logic                fwd_hs;
  logic                bwd_hs;
  logic                pop_bit;
  logic                full;
  logic                empty;
  logic [CW-1:0]       cnt;

  logic                act_valid_q;
  logic [BITWIDTH-1:0] act_q;
  logic                grad_valid_q;
  logic [BITWIDTH-1:0] grad_q;

  always_comb begin
    m = bus.fwd_data[BITWIDTH-1];
`ifdef RELU_NAN_PROPAGATE_EN
    if (relu_is_nan(float_t'(bus.fwd_data))) m = 1'b0;
`endif
    relu_out = m ? BITWIDTH'(FLOAT_ZERO) : bus.fwd_data;
  end

  // A pop never frees a slot for a push in the same cycle, and a
  // push never feeds a pop in the same cycle: status is registered.
  assign bus.fwd_ready = !rst && !full && (!act_valid_q || bus.act_ready);
  assign bus.bwd_ready = !rst && !empty && (!grad_valid_q || bus.grad_ready);

  assign fwd_hs = bus.fwd_valid && bus.fwd_ready && !clear;
  assign bwd_hs = bus.bwd_valid && bus.bwd_ready && !clear;

  relu_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fwd_hs),
    .din   (m),
    .pop   (bwd_hs),
    .dout  (pop_bit),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid_q <= 1'b0;
      act_q       <= '0;
    end else if (clear) begin
      act_valid_q <= 1'b0;
      act_q       <= '0;
    end else if (fwd_hs) begin
      act_valid_q <= 1'b1;
      act_q       <= relu_out;
    end else if (bus.act_ready) begin
      act_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grad_valid_q <= 1'b0;
      grad_q       <= '0;
    end else if (clear) begin
      grad_valid_q <= 1'b0;
      grad_q       <= '0;
    end else if (bwd_hs) begin
      grad_valid_q <= 1'b1;
      grad_q       <= pop_bit ? BITWIDTH'(FLOAT_ZERO) : bus.bwd_grad;
    end else if (bus.grad_ready) begin
      grad_valid_q <= 1'b0;
    end
  end

  assign bus.act_valid  = act_valid_q;
  assign bus.act_data   = act_q;
  assign bus.grad_valid = grad_valid_q;
  assign bus.grad_data  = grad_q;
  assign bus.mask_count = cnt;
  assign bus.mask_full  = full;
  assign bus.mask_empty = empty;

endmodule

// File: tb/tb_relu_fwd_mask.sv
// tb_relu_fwd_mask: directed self-checking bench for relu_fwd_mask.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_relu_fwd_mask;
  import relu_pkg::*;

  logic clk;
  logic rst;
  logic clear;

  int n_tests = 0;
  int n_fail  = 0;

  logic q[64];

  relu_fwd_mask_if #(.BITWIDTH(32), .DEPTH(64)) bus ();

  relu_fwd_mask #(
    .BITWIDTH (32),
    .DEPTH    (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = d;
    chk("fwd_ready", 32'(bus.fwd_ready), 1);
    @(negedge clk);
    bus.fwd_valid = 1'b0;
    chk("act_valid", 32'(bus.act_valid), 1);
    chk("act_data", bus.act_data, e);
  endtask

  task automatic pop(input logic [31:0] g, input logic [31:0] e);
    @(negedge clk);
    bus.bwd_valid = 1'b1;
    bus.bwd_grad  = g;
    chk("bwd_ready", 32'(bus.bwd_ready), 1);
    @(negedge clk);
    bus.bwd_valid = 1'b0;
    chk("grad_valid", 32'(bus.grad_valid), 1);
    chk("grad_data", bus.grad_data, e);
  endtask

  // Leaves 10 masks queued with act and grad outputs both valid.
  task automatic fill10();
    @(negedge clk);
    bus.act_ready  = 1'b1;
    bus.grad_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      push(32'h3F000000 | 32'(i), 32'h3F000000 | 32'(i));
    pop(FLOAT_1, FLOAT_1);
    @(negedge clk);
    bus.act_ready = 1'b0;
    push(32'h40000000, 32'h40000000);
    chk("fill_count", 32'(bus.mask_count), 10);
    chk("fill_act_v", 32'(bus.act_valid), 1);
    chk("fill_grad_v", 32'(bus.grad_valid), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [31:0] d;
    rst            = 1'b1;
    clear          = 1'b0;
    bus.fwd_valid  = 1'b0;
    bus.fwd_data   = '0;
    bus.act_ready  = 1'b0;
    bus.bwd_valid  = 1'b0;
    bus.bwd_grad   = '0;
    bus.grad_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_act_v", 32'(bus.act_valid), 0);
    chk("rst_grad_v", 32'(bus.grad_valid), 0);
    chk("rst_act_d", bus.act_data, 0);
    chk("rst_grad_d", bus.grad_data, 0);
    chk("rst_count", 32'(bus.mask_count), 0);
    chk("rst_empty", 32'(bus.mask_empty), 1);
    chk("rst_full", 32'(bus.mask_full), 0);
    chk("rst_fwd_rdy", 32'(bus.fwd_ready), 0);
    chk("rst_bwd_rdy", 32'(bus.bwd_ready), 0);
    rst            = 1'b0;
    bus.act_ready  = 1'b1;
    bus.grad_ready = 1'b1;

    // basic forward / backward
    push(32'h40400000, 32'h40400000);
    push(32'hC0000000, 32'h00000000);
    chk("cnt2", 32'(bus.mask_count), 2);
    pop(32'h3F000000, 32'h3F000000);
    pop(32'h3F000000, 32'h00000000);
    chk("cnt0", 32'(bus.mask_count), 0);
    chk("empty0", 32'(bus.mask_empty), 1);

    // -0.0 and NaN
    push(32'h80000000, 32'h00000000);
`ifdef RELU_NAN_PROPAGATE_EN
    push(32'hFFC00000, 32'hFFC00000);
`else
    push(32'hFFC00000, 32'h00000000);
`endif
    pop(FLOAT_1, 32'h00000000);
`ifdef RELU_NAN_PROPAGATE_EN
    pop(FLOAT_1, FLOAT_1);
`else
    pop(FLOAT_1, 32'h00000000);
`endif

    // fill to full, wrap pointers, check order
    for (int i = 0; i < 64; i++) begin
      q[i] = (i % 3 == 0);
      d = q[i] ? (32'hBF000000 | 32'(i)) : (32'h3F000000 | 32'(i));
      push(d, q[i] ? 32'h0 : d);
    end
    chk("full", 32'(bus.mask_full), 1);
    chk("full_cnt", 32'(bus.mask_count), 64);
    chk("full_fwd_rdy", 32'(bus.fwd_ready), 0);
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = FLOAT_1;
    bus.bwd_valid = 1'b1;
    bus.bwd_grad  = 32'h40000000;
    chk("both_fwd_rdy", 32'(bus.fwd_ready), 0);
    chk("both_bwd_rdy", 32'(bus.bwd_ready), 1);
    @(negedge clk);
    bus.fwd_valid = 1'b0;
    bus.bwd_valid = 1'b0;
    chk("both_cnt", 32'(bus.mask_count), 63);
    chk("both_act_v", 32'(bus.act_valid), 0);
    chk("both_grad_v", 32'(bus.grad_valid), 1);
    chk("both_grad_d", bus.grad_data, q[0] ? 32'h0 : 32'h40000000);
    for (int i = 1; i < 64; i++) begin
      g = 32'h40000000 | 32'(i);
      pop(g, q[i] ? 32'h0 : g);
    end
    chk("wrap_empty", 32'(bus.mask_empty), 1);

    // act backpressure
    bus.act_ready = 1'b0;
    push(32'h40000000, 32'h40000000);
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = 32'hC0800000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_act_v", 32'(bus.act_valid), 1);
      chk("bp_act_d", bus.act_data, 32'h40000000);
      chk("bp_fwd_rdy", 32'(bus.fwd_ready), 0);
    end
    bus.act_ready = 1'b1;
    @(negedge clk);
    bus.fwd_valid = 1'b0;
    chk("bp_rel_v", 32'(bus.act_valid), 1);
    chk("bp_rel_d", bus.act_data, 32'h00000000);
    chk("bp_cnt", 32'(bus.mask_count), 2);
    @(negedge clk);
    chk("bp_drain_v", 32'(bus.act_valid), 0);
    pop(FLOAT_1, FLOAT_1);
    pop(FLOAT_1, 32'h00000000);
    chk("bp_cnt0", 32'(bus.mask_count), 0);

    // clear mid-stream
    fill10();
    clear          = 1'b1;
    bus.act_ready  = 1'b1;
    bus.grad_ready = 1'b1;
    bus.fwd_valid  = 1'b1;
    bus.fwd_data   = 32'h40400000;
    bus.bwd_valid  = 1'b1;
    bus.bwd_grad   = FLOAT_1;
    @(negedge clk);
    clear         = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.bwd_valid = 1'b0;
    chk("clr_cnt", 32'(bus.mask_count), 0);
    chk("clr_empty", 32'(bus.mask_empty), 1);
    chk("clr_act_v", 32'(bus.act_valid), 0);
    chk("clr_grad_v", 32'(bus.grad_valid), 0);
    push(32'hC0400000, 32'h00000000);
    chk("clr_cnt1", 32'(bus.mask_count), 1);
    pop(FLOAT_1, 32'h00000000);
    chk("clr_cnt0", 32'(bus.mask_count), 0);

    // reset mid-stream
    fill10();
    rst = 1'b1;
    #1;
    chk("mrst_cnt", 32'(bus.mask_count), 0);
    chk("mrst_act_v", 32'(bus.act_valid), 0);
    chk("mrst_grad_v", 32'(bus.grad_valid), 0);
    chk("mrst_act_d", bus.act_data, 0);
    chk("mrst_grad_d", bus.grad_data, 0);
    chk("mrst_fwd_rdy", 32'(bus.fwd_ready), 0);
    chk("mrst_bwd_rdy", 32'(bus.bwd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_empty", 32'(bus.mask_empty), 1);
    chk("post_full", 32'(bus.mask_full), 0);
    chk("post_fwd_rdy", 32'(bus.fwd_ready), 1);
    bus.act_ready  = 1'b1;
    bus.grad_ready = 1'b1;
    push(32'h40400000, 32'h40400000);
    pop(32'h3F000000, 32'h3F000000);
    chk("post_cnt0", 32'(bus.mask_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
